// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM cash dispenser.
package atm_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_AMOUNT  = 2'd1;
    localparam logic [1:0] ERR_COMPOSE = 2'd2;
    localparam logic [1:0] ERR_JAM     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PLAN,
        ST_DISPENSE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAIL
    } disp_state_t;

    localparam int unsigned DENOM0_DEF     = 200;
    localparam int unsigned DENOM1_DEF     = 100;
    localparam int unsigned DENOM2_DEF     = 50;
    localparam int unsigned DENOM3_DEF     = 10;
    localparam int unsigned INIT_NOTES_DEF = 10;

endpackage

// File: rtl/atm_note_inventory.sv
// Per-slot note inventory: saturating refill-add, single-note decrement.
module atm_note_inventory
    import atm_pkg::*;
#(
    parameter logic [15:0] INIT_NOTES = 16'd10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refill_en,
    input  slot_t            refill_slot,
    input  logic [15:0]      refill_count,
    input  logic             dec_en,
    input  slot_t            dec_slot,
    output logic [3:0][15:0] inv
);

    logic [3:0][15:0] inv_q;
    logic [3:0][15:0] inv_d;
    logic [16:0]      sum;

    // Next inventory: refill only happens in idle and decrement only while
    // dispensing, so the two never collide on the same cycle.
    always_comb begin
        inv_d = inv_q;
        sum   = {1'b0, inv_q[refill_slot]} + {1'b0, refill_count};
        if (refill_en) begin
            inv_d[refill_slot] = sum[16] ? 16'hFFFF : sum[15:0];
        end
        if (dec_en && (inv_q[dec_slot] != 16'd0)) begin
            inv_d[dec_slot] = inv_q[dec_slot] - 16'd1;
        end
    end

    // Inventory registers, reloaded to the initial stock on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_q <= {4{INIT_NOTES}};
        end else begin
            inv_q <= inv_d;
        end
    end

    assign inv = inv_q;

endmodule

// File: rtl/atm_cash_dispenser.sv
// Cash dispenser: greedy inventory-limited note plan, then one-note-at-a-time
// feeder handshake.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for start; refills accepted here only
// ST_CHECK    | range-check captured amount, seed plan
// ST_PLAN     | one greedy step per cycle over slots 0..3
// ST_DISPENSE | pick next slot with notes left in plan, raise note_req
// ST_WAIT_ACK | hold note_req until ack or jam timeout
// ST_DONE     | one-cycle done pulse
// ST_FAIL     | one-cycle fail pulse, err_code holds the reason
module atm_cash_dispenser
    import atm_pkg::*;
#(
    parameter int unsigned DENOM0      = DENOM0_DEF,
    parameter int unsigned DENOM1      = DENOM1_DEF,
    parameter int unsigned DENOM2      = DENOM2_DEF,
    parameter int unsigned DENOM3      = DENOM3_DEF,
    parameter int unsigned INIT_NOTES  = INIT_NOTES_DEF,
    parameter logic [31:0] MAX_AMOUNT  = 32'h000186A0,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] amount,
    output logic        busy,
    output logic        note_req,
    output logic [1:0]  note_denom,
    input  logic        note_ack,
    output logic        done,
    output logic        fail,
    output logic [1:0]  err_code,
    output logic [31:0] dispensed_total,
    input  logic        refill_valid,
    input  logic [1:0]  refill_slot,
    input  logic [15:0] refill_count,
    output logic [15:0] inv0,
    output logic [15:0] inv1,
    output logic [15:0] inv2,
    output logic [15:0] inv3
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT);

    function automatic logic [31:0] denom_of(input slot_t s);
        case (s)
            2'd0:    return 32'(DENOM0);
            2'd1:    return 32'(DENOM1);
            2'd2:    return 32'(DENOM2);
            default: return 32'(DENOM3);
        endcase
    endfunction

    disp_state_t      state_q, state_d;
    logic [31:0]      amount_q, amount_d;
    logic [31:0]      rem_q, rem_d;
    slot_t            d_q, d_d;
    logic [3:0][15:0] plan_q, plan_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             busy_q, busy_d;
    logic             note_req_q, note_req_d;
    logic [31:0]      total_q, total_d;
    logic [1:0]       err_q, err_d;

    logic             refill_en;
    logic             dec_en;
    logic [31:0]      cur_denom;
    logic [3:0][15:0] inv_w;

    atm_note_inventory #(
        .INIT_NOTES (16'(INIT_NOTES))
    ) u_inv (
        .clk          (clk),
        .reset        (reset),
        .refill_en    (refill_en),
        .refill_slot  (refill_slot),
        .refill_count (refill_count),
        .dec_en       (dec_en),
        .dec_slot     (d_q),
        .inv          (inv_w)
    );

    assign cur_denom = denom_of(d_q);

    // Next-state, plan and handshake logic.
    always_comb begin
        state_d    = state_q;
        amount_d   = amount_q;
        rem_d      = rem_q;
        d_d        = d_q;
        plan_d     = plan_q;
        tmr_d      = tmr_q;
        busy_d     = busy_q;
        note_req_d = note_req_q;
        total_d    = total_q;
        err_d      = err_q;
        refill_en  = 1'b0;
        dec_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    amount_d = amount;
                    total_d  = '0;
                    err_d    = ERR_NONE;
                    busy_d   = 1'b1;
                    state_d  = ST_CHECK;
                end else begin
                    refill_en = refill_valid;
                end
            end
            ST_CHECK: begin
                if ((amount_q == 32'd0) || (amount_q > MAX_AMOUNT)) begin
                    err_d   = ERR_AMOUNT;
                    busy_d  = 1'b0;
                    state_d = ST_FAIL;
                end else begin
                    rem_d   = amount_q;
                    d_d     = 2'd0;
                    plan_d  = '0;
                    state_d = ST_PLAN;
                end
            end
            ST_PLAN: begin
                if ((rem_q >= cur_denom) && (plan_q[d_q] < inv_w[d_q])) begin
                    rem_d       = rem_q - cur_denom;
                    plan_d[d_q] = plan_q[d_q] + 16'd1;
                end else if (d_q == 2'd3) begin
                    d_d = 2'd0;
                    if (rem_q == 32'd0) begin
                        state_d = ST_DISPENSE;
                    end else begin
                        err_d   = ERR_COMPOSE;
                        busy_d  = 1'b0;
                        state_d = ST_FAIL;
                    end
                end else begin
                    d_d = d_q + 2'd1;
                end
            end
            ST_DISPENSE: begin
                if (plan_q[d_q] == 16'd0) begin
                    if (d_q == 2'd3) begin
                        d_d     = 2'd0;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        d_d = d_q + 2'd1;
                    end
                end else begin
                    note_req_d = 1'b1;
                    tmr_d      = TMR_LOAD;
                    state_d    = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (note_ack) begin
                    note_req_d  = 1'b0;
                    dec_en      = 1'b1;
                    plan_d[d_q] = plan_q[d_q] - 16'd1;
                    total_d     = total_q + cur_denom;
                    state_d     = ST_DISPENSE;
                end else if (tmr_q == '0) begin
                    note_req_d = 1'b0;
                    err_d      = ERR_JAM;
                    busy_d     = 1'b0;
                    state_d    = ST_FAIL;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            amount_q   <= '0;
            rem_q      <= '0;
            d_q        <= 2'd0;
            plan_q     <= '0;
            tmr_q      <= '0;
            busy_q     <= 1'b0;
            note_req_q <= 1'b0;
            total_q    <= '0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            amount_q   <= amount_d;
            rem_q      <= rem_d;
            d_q        <= d_d;
            plan_q     <= plan_d;
            tmr_q      <= tmr_d;
            busy_q     <= busy_d;
            note_req_q <= note_req_d;
            total_q    <= total_d;
            err_q      <= err_d;
        end
    end

    assign busy            = busy_q;
    assign note_req        = note_req_q;
    assign note_denom      = d_q;
    assign done            = (state_q == ST_DONE);
    assign fail            = (state_q == ST_FAIL);
    assign err_code        = err_q;
    assign dispensed_total = total_q;
    assign inv0            = inv_w[0];
    assign inv1            = inv_w[1];
    assign inv2            = inv_w[2];
    assign inv3            = inv_w[3];

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Directed bench for atm_cash_dispenser: vector table plus corner sequences.
module tb_atm_cash_dispenser;
    import atm_pkg::*;

    localparam int ACK_TO = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] amount;
    logic        busy;
    logic        note_req;
    logic [1:0]  note_denom;
    logic        note_ack;
    logic        done;
    logic        fail;
    logic [1:0]  err_code;
    logic [31:0] dispensed_total;
    logic        refill_valid;
    logic [1:0]  refill_slot;
    logic [15:0] refill_count;
    logic [15:0] inv0, inv1, inv2, inv3;

    atm_cash_dispenser dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .amount          (amount),
        .busy            (busy),
        .note_req        (note_req),
        .note_denom      (note_denom),
        .note_ack        (note_ack),
        .done            (done),
        .fail            (fail),
        .err_code        (err_code),
        .dispensed_total (dispensed_total),
        .refill_valid    (refill_valid),
        .refill_slot     (refill_slot),
        .refill_count    (refill_count),
        .inv0            (inv0),
        .inv1            (inv1),
        .inv2            (inv2),
        .inv3            (inv3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit          do_rst;
        logic [31:0] amt;
        bit          exp_ok;
        logic [1:0]  exp_err;
        logic [31:0] exp_total;
        int          exp_notes;
        logic [31:0] exp_seq;    // note i slot index at bits [2i+1:2i]
        logic [15:0] exp_inv0, exp_inv1, exp_inv2, exp_inv3;
        int          exp_lat;    // fail cycle after start drive, -1 = unchecked
    } vec_t;

    function automatic vec_t mkv(bit r, logic [31:0] a, bit ok, logic [1:0] e,
                                 logic [31:0] t, int n, logic [31:0] s,
                                 logic [15:0] i0, logic [15:0] i1,
                                 logic [15:0] i2, logic [15:0] i3, int lat);
        vec_t v;
        v.do_rst = r; v.amt = a; v.exp_ok = ok; v.exp_err = e; v.exp_total = t;
        v.exp_notes = n; v.exp_seq = s;
        v.exp_inv0 = i0; v.exp_inv1 = i1; v.exp_inv2 = i2; v.exp_inv3 = i3;
        v.exp_lat = lat;
        return v;
    endfunction

    // Results of the last request.
    bit          r_done, r_fail;
    int          r_end_cyc, r_rise_cyc, r_notes;
    logic [31:0] r_seq;

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; note_ack = 1'b0; refill_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue one request and act as the feeder, acking up to ack_max notes.
    task automatic run_req(input logic [31:0] amt, input int ack_max);
        int  cyc;
        int  acks;
        bit  prev_req;
        @(posedge clk); #1;
        start = 1'b1; amount = amt;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; acks = 0; prev_req = 1'b0;
        r_done = 1'b0; r_fail = 1'b0; r_notes = 0; r_seq = '0;
        r_end_cyc = -1; r_rise_cyc = -1;
        while (cyc < 5000) begin
            if (done || fail) begin
                r_done = done; r_fail = fail; r_end_cyc = cyc;
                break;
            end
            if (note_req && !prev_req) r_rise_cyc = cyc;
            prev_req = note_req;
            if (note_ack) begin
                note_ack = 1'b0;
            end else if (note_req && acks < ack_max) begin
                if (r_notes < 16) r_seq[2*r_notes +: 2] = note_denom;
                r_notes++;
                acks++;
                note_ack = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        note_ack = 1'b0;
        if (r_end_cyc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_bound: amount %0d no done/fail within %0d cycles", amt, cyc);
        end
    endtask

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        bit seen_pulse;
        int dw;

        vecs[0] = mkv(1, 32'd380,    1, ERR_NONE,    32'd380,  6,  32'h00000FE4, 9, 9, 9, 7, -1);
        vecs[1] = mkv(1, 32'd2500,   1, ERR_NONE,    32'd2500, 15, 32'h15500000, 0, 5, 10, 10, -1);
        vecs[2] = mkv(0, 32'd375,    0, ERR_COMPOSE, 32'd0,    0,  32'h0,        0, 5, 10, 10, -1);
        vecs[3] = mkv(0, 32'd60,     1, ERR_NONE,    32'd60,   2,  32'h0000000E, 0, 5, 9, 9, -1);
        vecs[4] = mkv(1, 32'd3700,   0, ERR_COMPOSE, 32'd0,    0,  32'h0,        10, 10, 10, 10, -1);
        vecs[5] = mkv(0, 32'd0,      0, ERR_AMOUNT,  32'd0,    0,  32'h0,        10, 10, 10, 10, 2);
        vecs[6] = mkv(0, 32'd100001, 0, ERR_AMOUNT,  32'd0,    0,  32'h0,        10, 10, 10, 10, 2);
        vecs[7] = mkv(0, 32'd100000, 0, ERR_COMPOSE, 32'd0,    0,  32'h0,        10, 10, 10, 10, -1);

        reset = 1'b1; start = 1'b0; amount = '0; note_ack = 1'b0;
        refill_valid = 1'b0; refill_slot = '0; refill_count = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_note_req", note_req, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err", err_code, 0);
        chk("rst_total", dispensed_total, 0);
        chk("rst_inv0", inv0, 10);
        chk("rst_inv3", inv3, 10);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].do_rst) do_reset();
            run_req(vecs[i].amt, 100);
            chk($sformatf("v%0d_done", i), r_done, vecs[i].exp_ok);
            chk($sformatf("v%0d_fail", i), r_fail, !vecs[i].exp_ok);
            chk($sformatf("v%0d_err", i), err_code, vecs[i].exp_err);
            chk($sformatf("v%0d_total", i), dispensed_total, vecs[i].exp_total);
            chk($sformatf("v%0d_notes", i), r_notes, vecs[i].exp_notes);
            chk($sformatf("v%0d_seq", i), r_seq, vecs[i].exp_seq);
            chk($sformatf("v%0d_inv0", i), inv0, vecs[i].exp_inv0);
            chk($sformatf("v%0d_inv1", i), inv1, vecs[i].exp_inv1);
            chk($sformatf("v%0d_inv2", i), inv2, vecs[i].exp_inv2);
            chk($sformatf("v%0d_inv3", i), inv3, vecs[i].exp_inv3);
            chk($sformatf("v%0d_busy", i), busy, 0);
            if (vecs[i].exp_lat >= 0)
                chk($sformatf("v%0d_latency", i), r_end_cyc, vecs[i].exp_lat);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse_end", i), done | fail, 0);
        end

        // Jam: only the first of two notes is acked.
        do_reset();
        run_req(32'd300, 1);
        chk("jam_fail", r_fail, 1);
        chk("jam_err", err_code, ERR_JAM);
        chk("jam_total", dispensed_total, 200);
        chk("jam_inv0", inv0, 9);
        chk("jam_inv1", inv1, 10);
        dw = r_end_cyc - r_rise_cyc;
        chk("jam_window", (dw >= ACK_TO && dw <= ACK_TO + 2), 1);

        // Saturating refill in idle; err_code must still hold the jam code.
        @(posedge clk); #1;
        refill_valid = 1'b1; refill_slot = 2'd2; refill_count = 16'd65530;
        @(posedge clk); #1;
        refill_valid = 1'b0;
        chk("refill_sat_inv2", inv2, 16'hFFFF);
        chk("err_held", err_code, ERR_JAM);

        // Refill while busy is ignored; reset during WAIT_ACK aborts silently.
        @(posedge clk); #1;
        start = 1'b1; amount = 32'd380;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        refill_valid = 1'b1; refill_slot = 2'd3; refill_count = 16'd5;
        @(posedge clk); #1;
        refill_valid = 1'b0;
        chk("refill_busy_inv3", inv3, 10);
        for (int k = 0; k < 100 && !note_req; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_note_req", note_req, 1);
        chk("mid_note_denom", note_denom, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_note_req", note_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_inv0", inv0, 10);
        chk("abort_inv2", inv2, 10);
        seen_pulse = 1'b0;
        repeat (2) @(posedge clk) begin
            #1 seen_pulse |= done | fail;
        end
        reset = 1'b0;
        repeat (4) @(posedge clk) begin
            #1 seen_pulse |= done | fail;
        end
        chk("abort_no_pulse", seen_pulse, 0);
        chk("abort_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
